// File: rtl/pendulum_pkg.sv
// Shared types and helpers for the pendulum balance controller.
package pendulum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } pend_state_t;

  // Neutral control value: half scale of a w-bit register.
  function automatic int unsigned ctrl_mid(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

  // Largest value of a w-bit control register.
  function automatic int unsigned ctrl_max(input int unsigned w);
    return (32'(1) << w) - 32'(1);
  endfunction

  // Magnitude of (angle - target), computed wide so it cannot overflow.
  function automatic int unsigned abs_err(input int unsigned a, input int unsigned t);
    return (a >= t) ? (a - t) : (t - a);
  endfunction

endpackage

// File: rtl/pendulum_pwm_gen.sv
// Free-running PWM counter, duty register and comparator for the cart motor.
module pendulum_pwm_gen #(
  parameter int unsigned DUTY_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] duty_q;

  // Counter runs in every state; hold forces the drive off while the loop is not running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      pwm     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + DUTY_W'(1);
      duty_q  <= hold ? '0 : duty;
      pwm     <= !hold && (duty_q > pwm_cnt);
    end
  end

endmodule

// File: rtl/pendulum_balance_ctrl.sv
// Closed-loop proportional balance controller with deadband, saturation and fault supervision.
module pendulum_balance_ctrl
  import pendulum_pkg::*;
#(
  parameter int unsigned ANGLE_W     = 8,
  parameter int unsigned CTRL_W      = 9,
  parameter int unsigned TARGET      = 128,
  parameter int unsigned DEADBAND    = 2,
  parameter int unsigned STEP_SHIFT  = 2,
  parameter int unsigned FAULT_LIMIT = 100,
  parameter int unsigned FAULT_COUNT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_valid,
  output logic               sample_ready,
  input  logic [ANGLE_W-1:0] angle,
  output logic [CTRL_W-1:0]  ctrl_value,
  output logic               motor_dir,
  output logic               motor_pwm,
  output logic               saturated,
  output logic               fault
);

  localparam int unsigned ERR_W  = ANGLE_W + 1;
  localparam int unsigned SUM_W  = ((CTRL_W > ERR_W) ? CTRL_W : ERR_W) + 1;
  localparam int unsigned DUTY_W = CTRL_W - 1;
  localparam int unsigned FCNT_W = $clog2(FAULT_COUNT + 1);

  localparam logic [CTRL_W-1:0] MID      = CTRL_W'(ctrl_mid(CTRL_W));
  localparam logic [CTRL_W-1:0] CTRL_TOP = CTRL_W'(ctrl_max(CTRL_W));
  localparam logic [CTRL_W-1:0] DUTY_TOP = MID - CTRL_W'(1);

  pend_state_t       state;
  logic [FCNT_W-1:0] fault_cnt;

  int unsigned       abs_i;
  int unsigned       step_i;
  logic              err_pos;
  logic              in_dead;
  logic              out_of_range;
  logic              accept;
  logic [SUM_W-1:0]  ctrl_ext;
  logic [SUM_W-1:0]  step_ext;
  logic [SUM_W-1:0]  sum_up;
  logic [CTRL_W-1:0] ctrl_upd;
  logic [CTRL_W-1:0] diff;
  logic [DUTY_W-1:0] duty;
  logic              pwm_hold;

  // Error magnitude, step size and clamped next control value for the current sample.
  always_comb begin
    abs_i        = abs_err(32'(angle), TARGET);
    err_pos      = 32'(angle) > TARGET;
    in_dead      = abs_i <= DEADBAND;
    out_of_range = abs_i > FAULT_LIMIT;
    step_i       = abs_i >> STEP_SHIFT;
    if (step_i == 0) begin
      step_i = 1;
    end
    ctrl_ext = SUM_W'(ctrl_value);
    step_ext = SUM_W'(step_i);
    sum_up   = ctrl_ext + step_ext;
    ctrl_upd = ctrl_value;
    if (!in_dead) begin
      if (err_pos) begin
        ctrl_upd = (sum_up > SUM_W'(CTRL_TOP)) ? CTRL_TOP : CTRL_W'(sum_up);
      end else begin
        ctrl_upd = (step_ext > ctrl_ext) ? '0 : CTRL_W'(ctrl_ext - step_ext);
      end
    end
  end

  // Handshake qualifier: a falling enable discards a coincident sample.
  always_comb begin
    accept = sample_valid && sample_ready && enable && (state == RUN);
  end

  // Drive magnitude relative to neutral, limited to the PWM range.
  always_comb begin
    diff = (ctrl_value >= MID) ? (ctrl_value - MID) : (MID - ctrl_value);
    duty = (diff > DUTY_TOP) ? DUTY_W'(DUTY_TOP) : DUTY_W'(diff);
    pwm_hold = (state != RUN);
  end

  // Enable/fault state machine together with the control and fault-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ctrl_value   <= MID;
      saturated    <= 1'b0;
      motor_dir    <= 1'b0;
      sample_ready <= 1'b0;
      fault        <= 1'b0;
      fault_cnt    <= '0;
    end else begin
      motor_dir <= (state == RUN) && (ctrl_value > MID);
      case (state)
        IDLE: begin
          ctrl_value <= MID;
          saturated  <= 1'b0;
          if (enable) begin
            state        <= RUN;
            sample_ready <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state        <= IDLE;
            sample_ready <= 1'b0;
            fault_cnt    <= '0;
          end else if (accept) begin
            ctrl_value <= ctrl_upd;
            saturated  <= (ctrl_upd == '0) || (ctrl_upd == CTRL_TOP);
            if (out_of_range) begin
              fault_cnt <= fault_cnt + FCNT_W'(1);
              if (fault_cnt == FCNT_W'(FAULT_COUNT - 1)) begin
                state        <= FAULT;
                sample_ready <= 1'b0;
                fault        <= 1'b1;
              end
            end else begin
              fault_cnt <= '0;
            end
          end
        end
        FAULT: begin
          ctrl_value <= MID;
          saturated  <= 1'b0;
          if (!enable) begin
            state     <= IDLE;
            fault     <= 1'b0;
            fault_cnt <= '0;
          end
        end
        default: begin
          state        <= IDLE;
          sample_ready <= 1'b0;
          fault        <= 1'b0;
        end
      endcase
    end
  end

  pendulum_pwm_gen #(
    .DUTY_W(DUTY_W)
  ) u_pwm (
    .clk   (clk),
    .reset (reset),
    .hold  (pwm_hold),
    .duty  (duty),
    .pwm   (motor_pwm)
  );

endmodule

// File: tb/tb_pendulum_balance_ctrl.sv
// Directed vector bench for pendulum_balance_ctrl.
module tb_pendulum_balance_ctrl;

  localparam int unsigned ANGLE_W = 8;
  localparam int unsigned CTRL_W  = 9;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic               sample_valid;
  logic               sample_ready;
  logic [ANGLE_W-1:0] angle;
  logic [CTRL_W-1:0]  ctrl_value;
  logic               motor_dir;
  logic               motor_pwm;
  logic               saturated;
  logic               fault;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] ang;
    int         ctrl;
    int         sat;
    int         dir;
    int         flt;
    int         rdy;
  } vec_t;

  vec_t vecs[22];

  always #5 clk = ~clk;

  pendulum_balance_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .angle        (angle),
    .ctrl_value   (ctrl_value),
    .motor_dir    (motor_dir),
    .motor_pwm    (motor_pwm),
    .saturated    (saturated),
    .fault        (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a);
    angle        = a;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    send(vecs[i].ang);
    check($sformatf("v%0d ctrl", i), 32'(ctrl_value), 32'(vecs[i].ctrl));
    check($sformatf("v%0d sat", i), 32'(saturated), 32'(vecs[i].sat));
    check($sformatf("v%0d fault", i), 32'(fault), 32'(vecs[i].flt));
    check($sformatf("v%0d ready", i), 32'(sample_ready), 32'(vecs[i].rdy));
    tick();
    check($sformatf("v%0d dir", i), 32'(motor_dir), 32'(vecs[i].dir));
  endtask

  task automatic count_pwm(output int n);
    n = 0;
    repeat (256) begin
      tick();
      if (motor_pwm) n++;
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{8'd140, 259, 0, 1, 0, 1};
    vecs[1] = '{8'd129, 259, 0, 1, 0, 1};
    vecs[2] = '{8'd131, 260, 0, 1, 0, 1};
    for (int k = 0; k < 11; k++) begin
      vecs[3 + k] = '{8'd228, (260 + 25 * (k + 1) > 511) ? 511 : 260 + 25 * (k + 1),
                      (k == 10) ? 1 : 0, 1, 0, 1};
    end
    vecs[14] = '{8'd0,   479, 0, 1, 0, 1};
    vecs[15] = '{8'd0,   447, 0, 1, 0, 1};
    vecs[16] = '{8'd0,   415, 0, 1, 0, 1};
    vecs[17] = '{8'd128, 415, 0, 1, 0, 1};
    vecs[18] = '{8'd0,   383, 0, 1, 0, 1};
    vecs[19] = '{8'd0,   351, 0, 1, 0, 1};
    vecs[20] = '{8'd0,   319, 0, 1, 0, 1};
    vecs[21] = '{8'd0,   287, 0, 0, 1, 0};

    reset        = 1'b1;
    enable       = 1'b0;
    sample_valid = 1'b0;
    angle        = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    check("rst ctrl", 32'(ctrl_value), 256);
    check("rst pwm", 32'(motor_pwm), 0);
    check("rst dir", 32'(motor_dir), 0);
    check("rst ready", 32'(sample_ready), 0);
    check("rst fault", 32'(fault), 0);
    check("rst sat", 32'(saturated), 0);

    // Samples offered in IDLE must be ignored.
    send(8'd200);
    check("idle ignore ctrl", 32'(ctrl_value), 256);

    enable = 1'b1;
    tick();
    check("run ready", 32'(sample_ready), 1);

    run_vec(0);
    repeat (3) tick();
    count_pwm(n);
    check("pwm duty3", 32'(n), 3);

    for (int i = 1; i <= 13; i++) run_vec(i);
    count_pwm(n);
    check("pwm duty max", 32'(n), 255);

    for (int i = 14; i <= 21; i++) run_vec(i);
    check("fault ctrl mid", 32'(ctrl_value), 256);
    check("fault held", 32'(fault), 1);

    // Samples in FAULT are not accepted.
    send(8'd140);
    check("fault no accept", 32'(ctrl_value), 256);
    check("fault ready", 32'(sample_ready), 0);
    count_pwm(n);
    check("fault pwm off", 32'(n), 0);
    check("fault dir", 32'(motor_dir), 0);

    enable = 1'b0;
    tick();
    check("idle fault clr", 32'(fault), 0);
    check("idle ready", 32'(sample_ready), 0);

    // Enable drop coincident with a valid sample discards that sample.
    enable = 1'b1;
    tick();
    send(8'd172);
    check("drop pre ctrl", 32'(ctrl_value), 267);
    enable       = 1'b0;
    angle        = 8'd228;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("drop discard ctrl", 32'(ctrl_value), 267);
    check("drop ready", 32'(sample_ready), 0);
    tick();
    check("drop idle mid", 32'(ctrl_value), 256);

    // Build ctrl_value = 300 then reset asynchronously mid-cycle.
    enable = 1'b1;
    tick();
    repeat (4) send(8'd172);
    check("pre reset ctrl", 32'(ctrl_value), 300);
    tick();
    check("pre reset dir", 32'(motor_dir), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async ctrl", 32'(ctrl_value), 256);
    check("async dir", 32'(motor_dir), 0);
    check("async ready", 32'(sample_ready), 0);
    check("async pwm", 32'(motor_pwm), 0);
    check("async fault", 32'(fault), 0);
    check("async sat", 32'(saturated), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("resume ready", 32'(sample_ready), 1);
    send(8'd140);
    check("resume ctrl", 32'(ctrl_value), 259);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
